// File: rtl/clock_mode_controller.sv
// Mode sequencer for the alarm clock.
// Decides who owns the time/alarm registers (running clock or adjust block),
// detects the alarm minute, drives the ring output and manages snooze with
// its own re-arm time. Target time and mode are registered outputs; the
// enables and load strobes are decoded from the current state.
`timescale 1ns/1ps

module clock_mode_controller #(
    parameter int unsigned SNOOZE_MIN   = 5,
    parameter int unsigned MAX_SNOOZES  = 3,
    parameter int unsigned RING_SECONDS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] button_pulse,
    input  logic       alarm_enable,
    input  logic [4:0] time_hours,
    input  logic [5:0] time_minutes,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic [1:0] adjusted,
    output logic       run_enable,
    output logic       adjust_enable,
    output logic       load_time,
    output logic       load_alarm,
    output logic       alarm_active,
    output logic       snooze_active,
    output logic [1:0] snooze_count,
    output logic [4:0] target_hours,
    output logic [5:0] target_minutes,
    output logic [2:0] mode
);

    localparam int unsigned       RING_W       = $clog2(RING_SECONDS + 1);
    localparam logic [RING_W-1:0] RING_LAST    = RING_W'(RING_SECONDS - 1);
    localparam logic [RING_W-1:0] RING_ONE     = RING_W'(1);
    localparam logic [1:0]        SNOOZE_LIMIT = 2'(MAX_SNOOZES);
    localparam logic [6:0]        SNOOZE_ADD   = 7'(SNOOZE_MIN);

    typedef enum logic [2:0] {
        ST_CLOCK   = 3'd0,
        ST_ADJUST  = 3'd1,
        ST_COMMIT  = 3'd2,
        ST_RINGING = 3'd3,
        ST_SNOOZED = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        snooze_count_reg, snooze_count_next;
    logic              snooze_active_reg, snooze_active_next;
    logic [4:0]        snooze_hours_reg, snooze_hours_next;
    logic [5:0]        snooze_minutes_reg, snooze_minutes_next;
    logic [4:0]        target_hours_reg, target_hours_next;
    logic [5:0]        target_minutes_reg, target_minutes_next;
    logic              match_prev_reg, match_prev_next;
    logic [RING_W-1:0] ring_count_reg, ring_count_next;

    // Button groups in the order they are prioritised while ringing.
    logic btn_centre;
    logic btn_updown;
    logic btn_side;

    assign btn_centre = button_pulse[0];
    assign btn_side   = button_pulse[1] | button_pulse[2];
    assign btn_updown = button_pulse[3] | button_pulse[4];

    // Alarm compare against the registered effective target; a trigger is
    // only the first cycle of a match, so each match minute rings once.
    logic match;
    logic trigger;

    assign match   = alarm_enable
                   && (time_hours == target_hours_reg)
                   && (time_minutes == target_minutes_reg);
    assign trigger = match && !match_prev_reg;

    // Snooze re-arm time: current time plus SNOOZE_MIN, wrapping minutes
    // into the hour and 23 into 0. The sum is kept at 7 bits so the
    // >= 60 compare sees the full value.
    logic [6:0] minute_sum;
    logic       minute_wrap;
    logic [4:0] snooze_hours_calc;
    logic [5:0] snooze_minutes_calc;

    // Compute the candidate snooze time every cycle from the running time.
    always_comb begin
        minute_sum          = {1'b0, time_minutes} + SNOOZE_ADD;
        minute_wrap         = (minute_sum >= 7'd60);
        snooze_minutes_calc = minute_sum[5:0];
        snooze_hours_calc   = time_hours;
        if (minute_wrap) begin
            snooze_minutes_calc = 6'(minute_sum - 7'd60);
            snooze_hours_calc   = (time_hours == 5'd23) ? 5'd0 : time_hours + 5'd1;
        end
    end

    // Next-state logic: mode transitions, snooze bookkeeping, ring timeout.
    always_comb begin
        logic clear_snooze;

        state_next          = state_reg;
        snooze_count_next   = snooze_count_reg;
        snooze_active_next  = snooze_active_reg;
        snooze_hours_next   = snooze_hours_reg;
        snooze_minutes_next = snooze_minutes_reg;
        ring_count_next     = ring_count_reg;
        match_prev_next     = match;
        clear_snooze        = 1'b0;

        unique case (state_reg)
            ST_CLOCK: begin
                // Centre beats a simultaneous trigger; the edge is still
                // consumed because match_prev follows match.
                if (btn_centre) begin
                    state_next = ST_ADJUST;
                end else if (trigger) begin
                    state_next      = ST_RINGING;
                    ring_count_next = '0;
                end
            end

            ST_ADJUST: begin
                if (btn_centre) begin
                    state_next = ST_COMMIT;
                end
            end

            ST_COMMIT: begin
                // A commit that lands on the alarm minute must not ring.
                state_next      = ST_CLOCK;
                clear_snooze    = 1'b1;
                match_prev_next = 1'b1;
            end

            ST_RINGING: begin
                if (!alarm_enable) begin
                    state_next   = ST_CLOCK;
                    clear_snooze = 1'b1;
                end else if (btn_centre || btn_updown) begin
                    state_next   = ST_CLOCK;
                    clear_snooze = 1'b1;
                end else if (btn_side && (snooze_count_reg < SNOOZE_LIMIT)) begin
                    state_next          = ST_SNOOZED;
                    snooze_count_next   = snooze_count_reg + 2'd1;
                    snooze_active_next  = 1'b1;
                    snooze_hours_next   = snooze_hours_calc;
                    snooze_minutes_next = snooze_minutes_calc;
                end else if (tick_1hz) begin
                    if (ring_count_reg == RING_LAST) begin
                        state_next      = ST_CLOCK;
                        clear_snooze    = 1'b1;
                        ring_count_next = '0;
                    end else begin
                        ring_count_next = ring_count_reg + RING_ONE;
                    end
                end
            end

            ST_SNOOZED: begin
                if (!alarm_enable) begin
                    state_next   = ST_CLOCK;
                    clear_snooze = 1'b1;
                end else if (btn_centre) begin
                    // Snooze stays pending through adjust and is dropped at commit.
                    state_next = ST_ADJUST;
                end else if (btn_updown) begin
                    state_next   = ST_CLOCK;
                    clear_snooze = 1'b1;
                end else if (trigger) begin
                    state_next      = ST_RINGING;
                    ring_count_next = '0;
                end
            end

            default: begin
                state_next   = ST_CLOCK;
                clear_snooze = 1'b1;
            end
        endcase

        if (clear_snooze) begin
            snooze_count_next  = 2'd0;
            snooze_active_next = 1'b0;
        end

        // Effective target follows the snooze time while a snooze is pending.
        if (snooze_active_next) begin
            target_hours_next   = snooze_hours_next;
            target_minutes_next = snooze_minutes_next;
        end else begin
            target_hours_next   = alarm_hours;
            target_minutes_next = alarm_minutes;
        end
    end

    // State and bookkeeping registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= ST_CLOCK;
            snooze_count_reg   <= 2'd0;
            snooze_active_reg  <= 1'b0;
            snooze_hours_reg   <= 5'd0;
            snooze_minutes_reg <= 6'd0;
            target_hours_reg   <= 5'd0;
            target_minutes_reg <= 6'd0;
            match_prev_reg     <= 1'b1;
            ring_count_reg     <= '0;
        end else begin
            state_reg          <= state_next;
            snooze_count_reg   <= snooze_count_next;
            snooze_active_reg  <= snooze_active_next;
            snooze_hours_reg   <= snooze_hours_next;
            snooze_minutes_reg <= snooze_minutes_next;
            target_hours_reg   <= target_hours_next;
            target_minutes_reg <= target_minutes_next;
            match_prev_reg     <= match_prev_next;
            ring_count_reg     <= ring_count_next;
        end
    end

    // Output decode from the registered state; load strobes exist only in COMMIT.
    always_comb begin
        run_enable    = 1'b0;
        adjust_enable = 1'b0;
        load_time     = 1'b0;
        load_alarm    = 1'b0;
        alarm_active  = 1'b0;
        unique case (state_reg)
            ST_CLOCK:   run_enable = 1'b1;
            ST_ADJUST:  adjust_enable = 1'b1;
            ST_COMMIT: begin
                load_time  = adjusted[0];
                load_alarm = adjusted[1];
            end
            ST_RINGING: begin
                run_enable   = 1'b1;
                alarm_active = 1'b1;
            end
            ST_SNOOZED: run_enable = 1'b1;
            default:    run_enable = 1'b0;
        endcase
    end

    assign snooze_active  = snooze_active_reg;
    assign snooze_count   = snooze_count_reg;
    assign target_hours   = target_hours_reg;
    assign target_minutes = target_minutes_reg;
    assign mode           = state_reg;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Randomised scoreboard bench for clock_mode_controller. A stimulus process
// plays the running clock and the buttons, steps a minute-arithmetic model
// of the mode rules and queues the expected outputs; a monitor pops one
// expectation per clock (or per mid-cycle reset) and compares.
`timescale 1ns/1ps

module tb_clock_mode_controller;

    localparam int SNOOZE_MIN   = 5;
    localparam int MAX_SNOOZES  = 3;
    localparam int RING_SECONDS = 60;
    localparam int PHASES       = 8;
    localparam int PHASE_CYCLES = 400;

    localparam int M_CLOCK   = 0;
    localparam int M_ADJUST  = 1;
    localparam int M_COMMIT  = 2;
    localparam int M_RINGING = 3;
    localparam int M_SNOOZED = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [4:0] button_pulse;
    logic       alarm_enable;
    logic [4:0] time_hours;
    logic [5:0] time_minutes;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [1:0] adjusted;
    logic       run_enable;
    logic       adjust_enable;
    logic       load_time;
    logic       load_alarm;
    logic       alarm_active;
    logic       snooze_active;
    logic [1:0] snooze_count;
    logic [4:0] target_hours;
    logic [5:0] target_minutes;
    logic [2:0] mode;

    clock_mode_controller #(
        .SNOOZE_MIN  (SNOOZE_MIN),
        .MAX_SNOOZES (MAX_SNOOZES),
        .RING_SECONDS(RING_SECONDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_1hz      (tick_1hz),
        .button_pulse  (button_pulse),
        .alarm_enable  (alarm_enable),
        .time_hours    (time_hours),
        .time_minutes  (time_minutes),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .adjusted      (adjusted),
        .run_enable    (run_enable),
        .adjust_enable (adjust_enable),
        .load_time     (load_time),
        .load_alarm    (load_alarm),
        .alarm_active  (alarm_active),
        .snooze_active (snooze_active),
        .snooze_count  (snooze_count),
        .target_hours  (target_hours),
        .target_minutes(target_minutes),
        .mode          (mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       run;
        logic       adj;
        logic       lt;
        logic       la;
        logic       ring;
        logic       snz;
        logic [1:0] cnt;
        logic [4:0] th;
        logic [5:0] tm;
        logic [2:0] mode;
    } snap_t;

    snap_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    event  chk_ev;

    // Reference model state (times held as plain minute counts / hours).
    int m_state, m_last_state, m_cnt, m_ring;
    int m_snz_h, m_snz_m, m_tgt_h, m_tgt_m;
    bit m_sa, m_prev;

    // Pending alarm/time jump, applied inside the next driven cycle.
    bit jump_req;
    int jump_ah, jump_am;

    function automatic string fmt(input snap_t s);
        return $sformatf("mode=%0d ring=%b snz=%b cnt=%0d tgt=%0d:%0d run=%b adj=%b lt=%b la=%b",
                         s.mode, s.ring, s.snz, s.cnt, s.th, s.tm, s.run, s.adj, s.lt, s.la);
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.run  = run_enable;
        s.adj  = adjust_enable;
        s.lt   = load_time;
        s.la   = load_alarm;
        s.ring = alarm_active;
        s.snz  = snooze_active;
        s.cnt  = snooze_count;
        s.th   = target_hours;
        s.tm   = target_minutes;
        s.mode = mode;
        return s;
    endfunction

    function automatic snap_t model_out();
        snap_t s;
        s.run  = (m_state == M_CLOCK) || (m_state == M_RINGING) || (m_state == M_SNOOZED);
        s.adj  = (m_state == M_ADJUST);
        s.lt   = (m_state == M_COMMIT) && adjusted[0];
        s.la   = (m_state == M_COMMIT) && adjusted[1];
        s.ring = (m_state == M_RINGING);
        s.snz  = m_sa;
        s.cnt  = 2'(m_cnt);
        s.th   = 5'(m_tgt_h);
        s.tm   = 6'(m_tgt_m);
        s.mode = 3'(m_state);
        return s;
    endfunction

    task automatic model_reset();
        m_state = M_CLOCK; m_last_state = M_CLOCK;
        m_cnt = 0; m_ring = 0; m_sa = 0; m_prev = 1;
        m_snz_h = 0; m_snz_m = 0; m_tgt_h = 0; m_tgt_m = 0;
    endtask

    // One clock of the mode rules, using the inputs currently driven.
    task automatic model_step();
        bit match, trig, clr, nprev;
        int ns, tot;
        match = alarm_enable && (int'(time_hours) == m_tgt_h) && (int'(time_minutes) == m_tgt_m);
        trig  = match && !m_prev;
        nprev = match;
        ns    = m_state;
        clr   = 0;
        case (m_state)
            M_CLOCK: begin
                if (button_pulse[0]) ns = M_ADJUST;
                else if (trig) begin ns = M_RINGING; m_ring = 0; end
            end
            M_ADJUST: if (button_pulse[0]) ns = M_COMMIT;
            M_COMMIT: begin ns = M_CLOCK; clr = 1; nprev = 1; end
            M_RINGING: begin
                if (!alarm_enable) begin ns = M_CLOCK; clr = 1; end
                else if (button_pulse[0] || button_pulse[3] || button_pulse[4]) begin
                    ns = M_CLOCK; clr = 1;
                end else if ((button_pulse[1] || button_pulse[2]) && m_cnt < MAX_SNOOZES) begin
                    tot     = (int'(time_hours) * 60 + int'(time_minutes) + SNOOZE_MIN) % 1440;
                    m_snz_h = tot / 60;
                    m_snz_m = tot % 60;
                    m_cnt   = m_cnt + 1;
                    m_sa    = 1;
                    ns      = M_SNOOZED;
                end else if (tick_1hz) begin
                    m_ring = m_ring + 1;
                    if (m_ring >= RING_SECONDS) begin ns = M_CLOCK; clr = 1; end
                end
            end
            M_SNOOZED: begin
                if (!alarm_enable) begin ns = M_CLOCK; clr = 1; end
                else if (button_pulse[0]) ns = M_ADJUST;
                else if (button_pulse[3] || button_pulse[4]) begin ns = M_CLOCK; clr = 1; end
                else if (trig) begin ns = M_RINGING; m_ring = 0; end
            end
            default: ns = M_CLOCK;
        endcase
        if (clr) begin m_cnt = 0; m_sa = 0; end
        if (m_sa) begin m_tgt_h = m_snz_h; m_tgt_m = m_snz_m; end
        else begin m_tgt_h = int'(alarm_hours); m_tgt_m = int'(alarm_minutes); end
        m_prev       = nprev;
        m_last_state = m_state;
        m_state      = ns;
    endtask

    task automatic set_time(input int tot);
        int t;
        t = ((tot % 1440) + 1440) % 1440;
        time_hours   = 5'(t / 60);
        time_minutes = 6'(t % 60);
    endtask

    // Drive one clock of random stimulus, step the model, queue the expectation.
    task automatic drive_cycle(input int rate);
        int r, k;
        @(negedge clk);
        reset        = 1'b0;
        r            = $urandom_range(0, 99);
        button_pulse = '0;
        case (m_state)
            M_ADJUST: if (r < 8) button_pulse = 5'b00001;
            M_RINGING: if (r < rate) begin
                k = $urandom_range(0, 9);
                if (k < 6)       button_pulse = (k % 2 == 0) ? 5'b00010 : 5'b00100;
                else if (k < 8)  button_pulse = (k == 6) ? 5'b01000 : 5'b10000;
                else if (k == 8) button_pulse = 5'b00001;
                else             button_pulse = 5'($urandom_range(1, 31));
            end
            default: if (rate > 0 && r < 2) begin
                k = $urandom_range(0, 5);
                button_pulse = (k == 5) ? 5'($urandom_range(1, 31)) : 5'(1 << k);
            end
        endcase
        tick_1hz     = ($urandom_range(0, 3) == 0);
        alarm_enable = ($urandom_range(0, 299) != 0);
        adjusted     = 2'($urandom_range(0, 3));
        if (jump_req) begin
            alarm_hours   = 5'(jump_ah);
            alarm_minutes = 6'(jump_am);
            set_time(jump_ah * 60 + jump_am - 2);
            jump_req = 0;
        end else if (m_state == M_CLOCK && m_last_state == M_COMMIT && $urandom_range(0, 1) == 1) begin
            // The adjusted time lands exactly on the alarm minute right after commit.
            time_hours   = 5'(m_tgt_h);
            time_minutes = 6'(m_tgt_m);
        end else if ((m_state == M_CLOCK || m_state == M_RINGING || m_state == M_SNOOZED)
                     && $urandom_range(0, 7) == 0) begin
            set_time(int'(time_hours) * 60 + int'(time_minutes) + 1);
        end
        model_step();
        exp_q.push_back(model_out());
    endtask

    // Reset asserted between edges while ringing; outputs must drop at once.
    task automatic reset_mid_cycle();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        exp_q.push_back(model_out());
        -> chk_ev;
        exp_q.push_back(model_out());
    endtask

    // Monitor: one comparison per clock (or per mid-cycle reset check).
    initial begin
        snap_t e, a;
        logic [2:0] last_mode;
        last_mode = 3'd0;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = dut_snap();
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got %s expected %s", $time, fmt(a), fmt(e));
                end
                if (a.mode != last_mode) begin
                    $display("t=%0t mode %0d->%0d time=%0d:%0d %s",
                             $time, last_mode, a.mode, time_hours, time_minutes, fmt(a));
                    last_mode = a.mode;
                end
            end
        end
    end

    // Stimulus: phases with fresh alarm times, some with buttons silent.
    initial begin
        int rate, ah, am;
        bit did_reset;
        snap_t rs, rx;
        reset         = 1'b1;
        tick_1hz      = 1'b0;
        button_pulse  = '0;
        alarm_enable  = 1'b1;
        adjusted      = 2'b00;
        alarm_hours   = 5'd7;
        alarm_minutes = 6'd0;
        set_time(6 * 60 + 58);
        jump_req  = 0;
        did_reset = 0;
        model_reset();

        repeat (2) @(negedge clk);
        rs = dut_snap();
        rx = model_out();
        vectors++;
        if (rs !== rx) begin
            miscompares++;
            $display("FAIL reset state t=%0t got %s expected %s", $time, fmt(rs), fmt(rx));
        end else begin
            $display("t=%0t reset state ok %s", $time, fmt(rs));
        end
        exp_q.push_back(model_out());

        for (int p = 0; p < PHASES; p++) begin
            if (p % 3 == 2) begin
                ah = 23; am = 58;
            end else if (p == 0) begin
                ah = 7; am = 0;
            end else begin
                ah = $urandom_range(0, 23); am = $urandom_range(0, 59);
            end
            rate = (p == 3 || p == 6) ? 0 : 12;
            for (int i = 0; i < PHASE_CYCLES; i++) begin
                if (i == 0 || i == PHASE_CYCLES / 2) begin
                    jump_req = 1; jump_ah = ah; jump_am = am;
                end
                if (p == 1 && !did_reset && m_state == M_RINGING && i > 20) begin
                    reset_mid_cycle();
                    did_reset = 1;
                end else begin
                    drive_cycle(rate);
                end
            end
        end

        fork
            wait (exp_q.size() == 0);
            repeat (20) @(posedge clk);
        join_any
        disable fork;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain timeout t=%0t %0d expectations never compared", $time, exp_q.size());
        end

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0) $display("PASS");
        else                  $display("FAIL");
        $finish;
    end

endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
Top-level mode sequencer for the alarm clock. It decides when the running clock counts, when the adjust datapath owns the time/alarm registers, and when adjusted values are committed back. It detects the alarm match, drives the ring output, and manages snooze with its own re-arm time. It sits between the debounced button pulses, the running time counter, and the adjust block.

Parameters:
SNOOZE_MIN, 5, minutes added to current time on snooze (1..59)
MAX_SNOOZES, 3, snoozes allowed per alarm event
RING_SECONDS, 60, 1 Hz ticks before an unanswered alarm self-dismisses

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick_1hz  input  1  one-cycle pulse per second from the timebase
button_pulse  input  5  one-cycle debounced pulses; [0]=centre, [1]=left, [2]=right, [3]=up, [4]=down
alarm_enable  input  1  alarm arm switch, level
time_hours  input  5  running clock hours 0..23
time_minutes  input  6  running clock minutes 0..59
alarm_hours  input  5  stored alarm hours 0..23
alarm_minutes  input  6  stored alarm minutes 0..59
adjusted  input  2  from adjust block; [1]=alarm changed, [0]=time changed
run_enable  output  1  running clock may count
adjust_enable  output  1  adjust block active
load_time  output  1  one-cycle pulse: load adjusted time into running clock
load_alarm  output  1  one-cycle pulse: load adjusted alarm into alarm register
alarm_active  output  1  buzzer/LED drive
snooze_active  output  1  snooze pending
snooze_count  output  2  snoozes used in current event
target_hours  output  5  effective alarm hours (alarm or snooze time)
target_minutes  output  6  effective alarm minutes
mode  output  3  state encoding for display

Behaviour:
- Reset (async): state=CLOCK; run_enable=1; all other outputs 0; target = 0:00; snooze_count=0; ring counter=0; match_prev=1 (no trigger possible on first cycle).
- State encoding: CLOCK=0, ADJUST=1, COMMIT=2, RINGING=3, SNOOZED=4; mode = state, registered.
- target = alarm_hours/minutes when snooze_active=0, else the internal snooze registers.
- match = alarm_enable && time_hours==target_hours && time_minutes==target_minutes. Trigger = match && !match_prev (rising edge); match_prev updates every cycle. Alarm fires once per match minute only.
- CLOCK: run_enable=1. Centre -> ADJUST. Trigger -> RINGING, ring counter cleared.
- ADJUST: run_enable=0, adjust_enable=1. Triggers are ignored. Centre -> COMMIT.
- COMMIT (exactly 1 cycle): load_time=adjusted[0], load_alarm=adjusted[1]. Snooze is cleared (snooze_active=0, count=0). Always -> CLOCK. match_prev is forced to 1 so a commit onto the alarm minute does not ring.
- RINGING: alarm_active=1, run_enable=1. Button priority is centre > up/down > left/right.
  - Centre or up/down: dismiss; clear snooze; -> CLOCK.
  - Left/right with snooze_count<MAX_SNOOZES: snooze_count+1, snooze time = current time + SNOOZE_MIN; -> SNOOZED.
  - Left/right at MAX_SNOOZES: ignored, keep ringing.
  - Ring counter increments on tick_1hz. On the tick that reaches RING_SECONDS: dismiss, clear snooze, -> CLOCK.
- SNOOZED: snooze_active=1, run_enable=1.
  - Trigger -> RINGING.
  - Up/down: cancel snooze -> CLOCK.
  - Centre -> ADJUST; snooze is cleared at COMMIT.
- Snooze arithmetic: m = time_minutes + SNOOZE_MIN. If m>=60: m-=60 and hour+1, with 23 wrapping to 0. Computed in 7 bits, no truncation before compare.
- alarm_enable low in RINGING or SNOOZED: next cycle -> CLOCK, snooze cleared. This has priority over buttons; reset alone outranks it.
- Simultaneous trigger and centre in CLOCK: centre wins (-> ADJUST). The edge is consumed, so no ring after commit.
- load_time and load_alarm are never asserted outside COMMIT. adjust_enable is high only in ADJUST.
- Reset mid-RINGING: alarm_active drops asynchronously; state returns to CLOCK.

Test Plan:
- Reset, then time 06:59→07:00 with alarm 07:00 and enable=1 -> alarm_active rises the cycle after time reaches 07:00, mode=3; holding 07:00 gives no retrigger after dismiss with up.
- Ringing at 07:00, right pulse -> SNOOZED, target=07:05, snooze_count=1; time reaches 07:05 -> ringing again; repeat to count=3; a 4th right pulse is ignored, still ringing.
- Time 23:58 ringing, snooze -> target 00:03; advance clock across midnight -> ring at 00:03.
- Ringing, no button, 60 tick_1hz pulses -> alarm_active falls on the 60th tick, mode=0, snooze_count=0.
- Centre in CLOCK -> run_enable=0, adjust_enable=1; adjusted=2'b01 then centre -> one-cycle load_time=1, load_alarm=0, back to CLOCK with run_enable=1; commit onto the alarm minute -> no ring.
- Snoozed at count 2, alarm_enable dropped -> next cycle mode=0, snooze_active=0, target=alarm value; assert reset during RINGING -> all outputs at reset values immediately.
